dot_accum: RTL and testbench

Accumulation stage of the dot-product datapath, directly downstream of the product pipeline register chain. Consumes one signed product per valid cycle (data and valid/last flags delayed together through the chain), sums products until a beat marked last, then presents the completed dot product and element count on a ready/valid output port. The upstream chain cannot stall, so no input backpressure exists; overruns are flagged, never silently merged.

---
 rtl/dotacc_pkg.sv | 16 +
 rtl/dotacc_add.sv | 51 +++++
 rtl/dot_accum.sv | 154 +++++++++++++++
 tb/tb_dot_accum.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/dotacc_pkg.sv
// dotacc_pkg: shared constants and types for the dot-product accumulation stage.
// Optional build macro used by this block: DOTACC_SATURATE_EN (see dotacc_add).
package dotacc_pkg;

    // Default widths for the product input, accumulator/result and element counter
    localparam int DOTACC_IN_WIDTH  = 32;
    localparam int DOTACC_ACC_WIDTH = 48;
    localparam int DOTACC_CNT_WIDTH = 16;

    // Input FSM: IDLE holds no partial sum, ACCUM holds one
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } dotacc_state_e;

endpackage

// File: rtl/dotacc_add.sv
// dotacc_add: combinational sign-extend and add of one product into the running sum.
// Build macro DOTACC_SATURATE_EN: when defined the sum clamps to the signed
// ACC_WIDTH range and reports the clamp on sat; otherwise the sum wraps and sat is 0.
module dotacc_add
    import dotacc_pkg::*;
#(
    parameter int IN_WIDTH  = DOTACC_IN_WIDTH,
    parameter int ACC_WIDTH = DOTACC_ACC_WIDTH
) (
    input  logic signed [ACC_WIDTH-1:0] acc,
    input  logic signed [IN_WIDTH-1:0]  din,
    output logic signed [ACC_WIDTH-1:0] sum,
    output logic                        sat
);

`ifdef DOTACC_SATURATE_EN
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    // One guard bit is enough to see overflow of a two-operand signed add
    function automatic logic overflowed(input logic signed [ACC_WIDTH:0] wide);
        return wide[ACC_WIDTH] != wide[ACC_WIDTH-1];
    endfunction

    // Clamp toward the sign of the true result when the guard bit disagrees
    function automatic logic signed [ACC_WIDTH-1:0] clamp(input logic signed [ACC_WIDTH:0] wide);
        if (!overflowed(wide))
            return wide[ACC_WIDTH-1:0];
        else if (wide[ACC_WIDTH])
            return ACC_MIN;
        else
            return ACC_MAX;
    endfunction

    logic signed [ACC_WIDTH:0] wide_sum;

    // Saturating add with a one-bit guard
    always_comb begin
        wide_sum = (ACC_WIDTH+1)'(acc) + (ACC_WIDTH+1)'(din);
        sum      = clamp(wide_sum);
        sat      = overflowed(wide_sum);
    end
`else
    // Wrapping add modulo 2^ACC_WIDTH; no clamp can occur
    always_comb begin
        sum = acc + ACC_WIDTH'(din);
        sat = 1'b0;
    end
`endif

endmodule

// File: rtl/dot_accum.sv
// dot_accum: accumulates signed products until a beat marked last, then offers the
// dot product, element count and saturation flag on a ready/valid output register.
// Upstream cannot stall: a completion that finds the output full and not draining
// is dropped and flagged on the sticky ERR_OVERRUN.
// Build macro DOTACC_SATURATE_EN selects clamping instead of wrapping additions.
module dot_accum
    import dotacc_pkg::*;
#(
    parameter int IN_WIDTH  = DOTACC_IN_WIDTH,
    parameter int ACC_WIDTH = DOTACC_ACC_WIDTH,
    parameter int CNT_WIDTH = DOTACC_CNT_WIDTH
) (
    input  logic                        CLK,
    input  logic                        RESETN,
    input  logic                        IN_VALID,
    input  logic                        IN_LAST,
    input  logic signed [IN_WIDTH-1:0]  IN_DATA,
    output logic                        OUT_VALID,
    input  logic                        OUT_READY,
    output logic signed [ACC_WIDTH-1:0] OUT_DATA,
    output logic [CNT_WIDTH-1:0]        OUT_COUNT,
    output logic                        OUT_SAT,
    output logic                        ERR_OVERRUN,
    input  logic                        ERR_CLR
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    dotacc_state_e               state_q;
    dotacc_state_e               state_d;

    // Stage p0: running partial sum of the current vector
    logic signed [ACC_WIDTH-1:0] acc_p0;
    logic [CNT_WIDTH-1:0]        cnt_p0;
    logic                        sat_p0;

    // Stage p1: completed result held for the consumer
    logic                        vld_p1;
    logic signed [ACC_WIDTH-1:0] data_p1;
    logic [CNT_WIDTH-1:0]        cnt_p1;
    logic                        sat_p1;
    logic                        err_q;

    logic                        first_beat;
    logic                        complete;
    logic                        out_load;
    logic                        out_drop;
    logic signed [ACC_WIDTH-1:0] add_base;
    logic signed [ACC_WIDTH-1:0] sum_next;
    logic                        add_sat;
    logic [CNT_WIDTH-1:0]        cnt_next;
    logic                        sat_next;

    // Input FSM state register
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Input FSM next state: open a vector on a non-last beat, close it on a last beat
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (IN_VALID && !IN_LAST) state_d = ACCUM;
            ACCUM:   if (IN_VALID && IN_LAST)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Input FSM outputs: whether this beat starts a vector and whether it completes one
    always_comb begin
        first_beat = 1'b0;
        complete   = IN_VALID && IN_LAST;
        case (state_q)
            IDLE:    first_beat = 1'b1;
            ACCUM:   first_beat = 1'b0;
            default: first_beat = 1'b1;
        endcase
    end

    // A fresh vector adds onto zero, so stale accumulator contents never leak in
    always_comb begin
        add_base = first_beat ? '0 : acc_p0;
        cnt_next = first_beat ? CNT_ONE : ((&cnt_p0) ? cnt_p0 : cnt_p0 + CNT_ONE);
        sat_next = add_sat || (!first_beat && sat_p0);
        out_load = complete && (!vld_p1 || OUT_READY);
        out_drop = complete && vld_p1 && !OUT_READY;
    end

    dotacc_add #(
        .IN_WIDTH  (IN_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_add (
        .acc (add_base),
        .din (IN_DATA),
        .sum (sum_next),
        .sat (add_sat)
    );

    // Stage p0 update: accumulate on every valid beat, clear once the vector completes
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            acc_p0 <= '0;
            cnt_p0 <= '0;
            sat_p0 <= 1'b0;
        end else if (IN_VALID) begin
            if (IN_LAST) begin
                acc_p0 <= '0;
                cnt_p0 <= '0;
                sat_p0 <= 1'b0;
            end else begin
                acc_p0 <= sum_next;
                cnt_p0 <= cnt_next;
                sat_p0 <= sat_next;
            end
        end
    end

    // Stage p1 output register: load when empty or draining, otherwise hold until accepted
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            cnt_p1  <= '0;
            sat_p1  <= 1'b0;
        end else if (out_load) begin
            vld_p1  <= 1'b1;
            data_p1 <= sum_next;
            cnt_p1  <= cnt_next;
            sat_p1  <= sat_next;
        end else if (OUT_READY) begin
            vld_p1  <= 1'b0;
        end
    end

    // Sticky overrun flag; a new drop in the same cycle as a clear keeps it set
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN)
            err_q <= 1'b0;
        else if (out_drop)
            err_q <= 1'b1;
        else if (ERR_CLR)
            err_q <= 1'b0;
    end

    assign OUT_VALID   = vld_p1;
    assign OUT_DATA    = data_p1;
    assign OUT_COUNT   = cnt_p1;
    assign OUT_SAT     = sat_p1;
    assign ERR_OVERRUN = err_q;

endmodule

// File: tb/tb_dot_accum.sv
// tb_dot_accum: scoreboard bench for dot_accum (default widths) plus a narrow
// 8/8/2 instance for clamp/wrap and counter-saturation boundaries.
module tb_dot_accum;
    import dotacc_pkg::*;

    localparam int IW = 32;
    localparam int AW = 48;
    localparam int CW = 16;

`ifdef DOTACC_SATURATE_EN
    localparam longint S_POS = 127;
    localparam longint S_NEG = -128;
    localparam longint S_FLG = 1;
`else
    localparam longint S_POS = -56;
    localparam longint S_NEG = 56;
    localparam longint S_FLG = 0;
`endif

    typedef struct packed {
        logic signed [AW-1:0] data;
        logic [CW-1:0]        cnt;
        logic                 sat;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic                 in_valid, in_last, out_valid, out_ready, out_sat, err_ovr, err_clr;
    logic signed [IW-1:0] in_data;
    logic signed [AW-1:0] out_data;
    logic [CW-1:0]        out_count;

    logic                 s_valid, s_last, s_ovalid, s_sat, s_err;
    logic signed [7:0]    s_data, s_odata;
    logic [1:0]           s_ocount;

    res_t sb[$];
    int   checks = 0;
    int   passed = 0;

    dot_accum #(.IN_WIDTH(IW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .CLK(clk), .RESETN(rst_n), .IN_VALID(in_valid), .IN_LAST(in_last), .IN_DATA(in_data),
        .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_DATA(out_data), .OUT_COUNT(out_count),
        .OUT_SAT(out_sat), .ERR_OVERRUN(err_ovr), .ERR_CLR(err_clr)
    );

    dot_accum #(.IN_WIDTH(8), .ACC_WIDTH(8), .CNT_WIDTH(2)) dut8 (
        .CLK(clk), .RESETN(rst_n), .IN_VALID(s_valid), .IN_LAST(s_last), .IN_DATA(s_data),
        .OUT_VALID(s_ovalid), .OUT_READY(1'b1), .OUT_DATA(s_odata), .OUT_COUNT(s_ocount),
        .OUT_SAT(s_sat), .ERR_OVERRUN(s_err), .ERR_CLR(1'b0)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic expect_res(input longint d, input int c, input logic s);
        res_t r;
        r.data = AW'(d);
        r.cnt  = CW'(c);
        r.sat  = s;
        sb.push_back(r);
    endtask

    task automatic beat(input longint d, input logic last);
        in_valid = 1'b1;
        in_data  = IW'(d);
        in_last  = last;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic sbeat(input longint d, input logic last);
        s_valid = 1'b1;
        s_data  = 8'(d);
        s_last  = last;
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Monitor: every accepted result must match the head of the scoreboard
    always @(negedge clk) begin
        res_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", longint'(out_data), -1);
            end else begin
                e = sb.pop_front();
                check("res_data",  longint'(out_data),  longint'(e.data));
                check("res_count", longint'(out_count), longint'(e.cnt));
                check("res_sat",   longint'(out_sat),   longint'(e.sat));
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        out_ready = 1'b0; err_clr = 1'b0;
        s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        idle(2);
        check("rst_valid", longint'(out_valid), 0);
        check("rst_data",  longint'(out_data), 0);
        check("rst_count", longint'(out_count), 0);
        check("rst_sat",   longint'(out_sat), 0);
        check("rst_err",   longint'(err_ovr), 0);
        rst_n = 1'b1;
        idle(1);

        // {3,-5,7}
        out_ready = 1'b1;
        expect_res(5, 3, 1'b0);
        beat(3, 1'b0); beat(-5, 1'b0); beat(7, 1'b1);
        check("latency_valid", longint'(out_valid), 1);
        idle(2);

        // single element from IDLE, then another single to show nothing was left behind
        expect_res(-9, 1, 1'b0);
        beat(-9, 1'b1);
        check("single_valid", longint'(out_valid), 1);
        expect_res(6, 1, 1'b0);
        beat(6, 1'b1);
        idle(2);

        // back-to-back {1,2},{10} with no consumer: second dropped
        out_ready = 1'b0;
        expect_res(3, 2, 1'b0);
        beat(1, 1'b0); beat(2, 1'b1); beat(10, 1'b1);
        check("ovr_flag", longint'(err_ovr), 1);
        check("ovr_held_data", longint'(out_data), 3);
        idle(2);
        check("ovr_stable_data",  longint'(out_data), 3);
        check("ovr_stable_count", longint'(out_count), 2);
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        check("err_cleared", longint'(err_ovr), 0);

        // drain of 3 and load of {4,4} in the same cycle
        beat(4, 1'b0);
        out_ready = 1'b1;
        expect_res(8, 2, 1'b0);
        beat(4, 1'b1);
        check("swap_valid", longint'(out_valid), 1);
        check("swap_data",  longint'(out_data), 8);
        idle(2);

        // ERR_CLR coinciding with a fresh overrun keeps the flag set
        out_ready = 1'b0;
        expect_res(1, 1, 1'b0);
        beat(1, 1'b1); beat(2, 1'b1);
        err_clr = 1'b1;
        beat(3, 1'b1);
        err_clr = 1'b0;
        check("clr_vs_set", longint'(err_ovr), 1);
        out_ready = 1'b1;
        idle(2);

        // reset with a result pending, overrun set and a partial {5,5}
        out_ready = 1'b0;
        beat(7, 1'b1); beat(1, 1'b1); beat(5, 1'b0); beat(5, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", longint'(out_valid), 0);
        check("mid_rst_data",  longint'(out_data), 0);
        check("mid_rst_count", longint'(out_count), 0);
        check("mid_rst_sat",   longint'(out_sat), 0);
        check("mid_rst_err",   longint'(err_ovr), 0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        out_ready = 1'b1;
        expect_res(2, 1, 1'b0);
        beat(2, 1'b1);
        idle(2);

        // narrow instance: positive and negative overflow, then counter saturation
        sbeat(100, 1'b0); sbeat(100, 1'b1);
        check("n8_pos_valid", longint'(s_ovalid), 1);
        check("n8_pos_data",  longint'(s_odata), S_POS);
        check("n8_pos_sat",   longint'(s_sat), S_FLG);
        check("n8_pos_count", longint'(s_ocount), 2);
        sbeat(-100, 1'b0); sbeat(-100, 1'b1);
        check("n8_neg_data",  longint'(s_odata), S_NEG);
        check("n8_neg_sat",   longint'(s_sat), S_FLG);
        for (int i = 0; i < 5; i++) sbeat(0, i == 4);
        check("n8_cnt_sat",   longint'(s_ocount), 3);
        check("n8_zero_data", longint'(s_odata), 0);
        check("n8_zero_sat",  longint'(s_sat), 0);

        repeat (20) if (sb.size() != 0) @(posedge clk);
        #1;
        check("scoreboard_drained", longint'(sb.size()), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
